// File: rtl/core_pkg.sv
// Shared RV32I encodings: opcodes, ALU operations, operand-select codes,
// and the decode/ID-EX bundles with their bubble values.
package core_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    alu_op: ALU_ADD, alu_src_a: SRC_A_RS1, alu_src_b: 1'b0, reg_write: 1'b0,
    mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, branch: 1'b0,
    jal: 1'b0, jalr: 1'b0, illegal: 1'b0
  };

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    ctrl_t       ctrl;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    pc: 32'd0, rs1_data: 32'd0, rs2_data: 32'd0, imm: 32'd0,
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, funct3: 3'd0, ctrl: CTRL_BUBBLE
  };

  function automatic logic [31:0] gen_imm(input imm_sel_e sel, input logic [31:0] inst);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'd0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // alt is inst[30]; it selects SUB only for register-register ops.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt,
                                              input logic is_reg_op);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Optional write-through bypass when DECODE_WB_BYPASS_EN is defined.
module regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0] mem_r [32];

  // Array storage; x0 is never written so it stays zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (wb_we && (wb_rd != 5'd0)) begin
      mem_r[wb_rd] <= wb_data;
    end
  end

  // Read ports, with same-cycle writeback forwarding in the bypass build.
  always_comb begin
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    if (rs1 == 5'd0) begin
      rs1_data = 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wb_we && (wb_rd == rs1)) begin
      rs1_data = wb_data;
`endif
    end else begin
      rs1_data = mem_r[rs1];
    end
    if (rs2 == 5'd0) begin
      rs2_data = 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wb_we && (wb_rd == rs2)) begin
      rs2_data = wb_data;
`endif
    end else begin
      rs2_data = mem_r[rs2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediates, register read, load-use
// hazard detection and the ID/EX register. Regfile bypass: DECODE_WB_BYPASS_EN.
module decode_stage
  import core_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_pc,
  input  logic [31:0] inst,
  input  logic        ex_flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        load_use_stall,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic [3:0]  ex_alu_op,
  output logic [1:0]  ex_alu_src_a,
  output logic        ex_alu_src_b,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic        ex_illegal
);

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  ctrl_t       ctrl_dec_s;
  ctrl_t       ctrl_s;
  imm_sel_e    imm_sel_s;
  logic        rs1_used_s;
  logic        rs2_used_s;
  logic [31:0] rs1_data_s;
  logic [31:0] rs2_data_s;
  logic        hazard_s;
  id_ex_t      id_ex_next_s;
  id_ex_t      id_ex_r;

  assign opcode_s = inst[6:0];
  assign rd_s     = inst[11:7];
  assign funct3_s = inst[14:12];
  assign rs1_s    = inst[19:15];
  assign rs2_s    = inst[24:20];

  regfile u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rs1      (rs1_s),
    .rs2      (rs2_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // Opcode decode into control bundle, immediate format and operand usage.
  always_comb begin
    ctrl_dec_s = CTRL_BUBBLE;
    imm_sel_s  = IMM_NONE;
    rs1_used_s = 1'b1;
    rs2_used_s = 1'b0;
    if (inst[1:0] != 2'b11) begin
      ctrl_dec_s.illegal = 1'b1;
    end else begin
      case (opcode_s)
        OPC_LUI: begin
          ctrl_dec_s.reg_write = 1'b1;
          ctrl_dec_s.alu_src_a = SRC_A_ZERO;
          ctrl_dec_s.alu_src_b = 1'b1;
          imm_sel_s            = IMM_U;
          rs1_used_s           = 1'b0;
        end
        OPC_AUIPC: begin
          ctrl_dec_s.reg_write = 1'b1;
          ctrl_dec_s.alu_src_a = SRC_A_PC;
          ctrl_dec_s.alu_src_b = 1'b1;
          imm_sel_s            = IMM_U;
        end
        OPC_JAL: begin
          ctrl_dec_s.reg_write = 1'b1;
          ctrl_dec_s.jal       = 1'b1;
          ctrl_dec_s.alu_src_a = SRC_A_PC;
          ctrl_dec_s.alu_src_b = 1'b1;
          imm_sel_s            = IMM_J;
          rs1_used_s           = 1'b0;
        end
        OPC_JALR: begin
          ctrl_dec_s.reg_write = 1'b1;
          ctrl_dec_s.jalr      = 1'b1;
          ctrl_dec_s.alu_src_b = 1'b1;
          imm_sel_s            = IMM_I;
        end
        OPC_BRANCH: begin
          ctrl_dec_s.branch = 1'b1;
          ctrl_dec_s.alu_op = ALU_SUB;
          imm_sel_s         = IMM_B;
          rs2_used_s        = 1'b1;
        end
        OPC_LOAD: begin
          ctrl_dec_s.reg_write  = 1'b1;
          ctrl_dec_s.mem_read   = 1'b1;
          ctrl_dec_s.mem_to_reg = 1'b1;
          ctrl_dec_s.alu_src_b  = 1'b1;
          imm_sel_s             = IMM_I;
        end
        OPC_STORE: begin
          ctrl_dec_s.mem_write = 1'b1;
          ctrl_dec_s.alu_src_b = 1'b1;
          imm_sel_s            = IMM_S;
          rs2_used_s           = 1'b1;
        end
        OPC_OP_IMM: begin
          ctrl_dec_s.reg_write = 1'b1;
          ctrl_dec_s.alu_src_b = 1'b1;
          ctrl_dec_s.alu_op    = alu_from_funct3(funct3_s, inst[30], 1'b0);
          imm_sel_s            = IMM_I;
        end
        OPC_OP: begin
          ctrl_dec_s.reg_write = 1'b1;
          ctrl_dec_s.alu_op    = alu_from_funct3(funct3_s, inst[30], 1'b1);
          rs2_used_s           = 1'b1;
        end
        OPC_MISC_MEM, OPC_SYSTEM: begin
          ctrl_dec_s = CTRL_BUBBLE;
        end
        default: begin
          ctrl_dec_s.illegal = 1'b1;
        end
      endcase
    end
  end

  // Writes to x0 are architectural no-ops, so never request them.
  always_comb begin
    ctrl_s           = ctrl_dec_s;
    ctrl_s.reg_write = ctrl_dec_s.reg_write && (rd_s != 5'd0);
  end

  assign hazard_s = id_ex_r.ctrl.mem_read && (id_ex_r.rd != 5'd0) &&
                    (((id_ex_r.rd == rs1_s) && rs1_used_s) ||
                     ((id_ex_r.rd == rs2_s) && rs2_used_s));
  // A flush squashes the load in EX, so there is nothing left to wait for.
  assign load_use_stall = hazard_s && !ex_flush;

  // ID/EX next value: flush and stall both insert a bubble.
  always_comb begin
    id_ex_next_s = ID_EX_BUBBLE;
    if (ex_flush) begin
      id_ex_next_s = ID_EX_BUBBLE;
    end else if (load_use_stall) begin
      id_ex_next_s = ID_EX_BUBBLE;
    end else begin
      id_ex_next_s.pc       = id_pc;
      id_ex_next_s.rs1_data = rs1_data_s;
      id_ex_next_s.rs2_data = rs2_data_s;
      id_ex_next_s.imm      = gen_imm(imm_sel_s, inst);
      id_ex_next_s.rs1      = rs1_s;
      id_ex_next_s.rs2      = rs2_s;
      id_ex_next_s.rd       = rd_s;
      id_ex_next_s.funct3   = funct3_s;
      id_ex_next_s.ctrl     = ctrl_s;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ex_r <= ID_EX_BUBBLE;
    end else begin
      id_ex_r <= id_ex_next_s;
    end
  end

  assign ex_pc         = id_ex_r.pc;
  assign ex_rs1_data   = id_ex_r.rs1_data;
  assign ex_rs2_data   = id_ex_r.rs2_data;
  assign ex_imm        = id_ex_r.imm;
  assign ex_rs1        = id_ex_r.rs1;
  assign ex_rs2        = id_ex_r.rs2;
  assign ex_rd         = id_ex_r.rd;
  assign ex_funct3     = id_ex_r.funct3;
  assign ex_alu_op     = id_ex_r.ctrl.alu_op;
  assign ex_alu_src_a  = id_ex_r.ctrl.alu_src_a;
  assign ex_alu_src_b  = id_ex_r.ctrl.alu_src_b;
  assign ex_reg_write  = id_ex_r.ctrl.reg_write;
  assign ex_mem_read   = id_ex_r.ctrl.mem_read;
  assign ex_mem_write  = id_ex_r.ctrl.mem_write;
  assign ex_mem_to_reg = id_ex_r.ctrl.mem_to_reg;
  assign ex_branch     = id_ex_r.ctrl.branch;
  assign ex_jal        = id_ex_r.ctrl.jal;
  assign ex_jalr       = id_ex_r.ctrl.jalr;
  assign ex_illegal    = id_ex_r.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues hand-computed
// expectations per cycle, a monitor checks the stall and next-cycle ID/EX.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] id_pc = 32'd0;
  logic [31:0] inst = 32'd0;
  logic        ex_flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        load_use_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_alu_src_a;
  logic        ex_alu_src_b, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_branch, ex_jal, ex_jalr, ex_illegal;

  decode_stage dut (
    .clock(clock), .reset(reset), .id_pc(id_pc), .inst(inst), .ex_flush(ex_flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .load_use_stall(load_use_stall),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_alu_op(ex_alu_op), .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] X4_SAME_CYCLE = 32'h0000_0055;
`else
  localparam logic [31:0] X4_SAME_CYCLE = 32'h0000_0011;
`endif

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch, jal, jalr}
  typedef struct {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic [1:0]  sa;
    logic        sb;
    logic [6:0]  ctl;
    logic        ill;
    logic        stall;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total = 0;
  int   bad = 0;
  logic busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, d1, d2, imm, input logic [4:0] rs1, rs2, rd,
                              input logic [2:0] f3, input logic [3:0] op, input logic [1:0] sa,
                              input logic sb, input logic [6:0] ctl, input logic ill, stall);
    exp_t e;
    e.pc = pc; e.d1 = d1; e.d2 = d2; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.f3 = f3; e.op = op; e.sa = sa; e.sb = sb; e.ctl = ctl; e.ill = ill; e.stall = stall;
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(load_use_stall), 32'd0);
    check({tag, "_pc"}, ex_pc, 32'd0);
    check({tag, "_d1"}, ex_rs1_data, 32'd0);
    check({tag, "_d2"}, ex_rs2_data, 32'd0);
    check({tag, "_imm"}, ex_imm, 32'd0);
    check({tag, "_fields"}, 32'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op, ex_alu_src_a, ex_alu_src_b}), 32'd0);
    check({tag, "_ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                              ex_branch, ex_jal, ex_jalr, ex_illegal}), 32'd0);
  endtask

  task automatic cyc(input logic [31:0] pc, ins, input logic fl, we, input logic [4:0] rd,
                     input logic [31:0] data, input exp_t e);
    id_pc = pc; inst = ins; ex_flush = fl; wb_we = we; wb_rd = rd; wb_data = data;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || busy); i++) #1;
    check("drain", 32'(q.size()) + 32'(busy), 32'd0);
  endtask

  // Monitor: stall is checked mid-cycle, the ID/EX contents just after the edge.
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() != 0) begin
        m = q.pop_front();
        busy = 1'b1;
        check("stall", 32'(load_use_stall), 32'(m.stall));
        @(posedge clock);
        #2;
        check("ex_pc", ex_pc, m.pc);
        check("ex_rs1_data", ex_rs1_data, m.d1);
        check("ex_rs2_data", ex_rs2_data, m.d2);
        check("ex_imm", ex_imm, m.imm);
        check("ex_idx", 32'({ex_rs1, ex_rs2, ex_rd}), 32'({m.rs1, m.rs2, m.rd}));
        check("ex_funct3", 32'(ex_funct3), 32'(m.f3));
        check("ex_alu", 32'({ex_alu_op, ex_alu_src_a, ex_alu_src_b}), 32'({m.op, m.sa, m.sb}));
        check("ex_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                             ex_branch, ex_jal, ex_jalr}), 32'(m.ctl));
        check("ex_illegal", 32'(ex_illegal), 32'(m.ill));
        busy = 1'b0;
      end
    end
  end

  initial begin
    exp_t nop_e, lw_e, bub_e;
    nop_e = mk(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, ADD, 2'd0, 1'b1, 7'b0, 1'b0, 1'b0);
    bub_e = mk(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 2'd0, 1'b0, 7'b0, 1'b0, 1'b0);
    #12;
    check_zero("reset");
    #10;
    reset = 1'b0;
    @(posedge clock);
    #1;
    // preload x1=5, x2=7, x4=0x11, x5=0x33
    cyc(32'd0, NOP, 1'b0, 1'b1, 5'd1, 32'd5, nop_e);
    cyc(32'd0, NOP, 1'b0, 1'b1, 5'd2, 32'd7, nop_e);
    cyc(32'd0, NOP, 1'b0, 1'b1, 5'd4, 32'h11, nop_e);
    cyc(32'd0, NOP, 1'b0, 1'b1, 5'd5, 32'h33, nop_e);
    // add x3,x1,x2 / beq -4 / lui
    cyc(32'h100, 32'h002081B3, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    cyc(32'h104, 32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h104, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd29, 3'd0, SUB, 2'd0, 1'b0, 7'b0000100, 1'b0, 1'b0));
    cyc(32'h108, 32'h123450B7, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h108, 32'd0, 32'd0, 32'h12345000, 5'd8, 5'd3, 5'd1, 3'd5, ADD, 2'd2, 1'b1, 7'b1000000, 1'b0, 1'b0));
    // lw x5,0(x1) then dependent add: one stall, bubble, then issue
    lw_e = mk(32'h10C, 32'd5, 32'd0, 32'd0, 5'd1, 5'd0, 5'd5, 3'd2, ADD, 2'd0, 1'b1, 7'b1101000, 1'b0, 1'b0);
    cyc(32'h10C, 32'h0000A283, 1'b0, 1'b0, 5'd0, 32'd0, lw_e);
    bub_e.stall = 1'b1;
    cyc(32'h110, 32'h00228333, 1'b0, 1'b0, 5'd0, 32'd0, bub_e);
    bub_e.stall = 1'b0;
    cyc(32'h110, 32'h00228333, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h110, 32'h33, 32'd7, 32'd0, 5'd5, 5'd2, 5'd6, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    // independent add after load: no stall
    lw_e.pc = 32'h114;
    cyc(32'h114, 32'h0000A283, 1'b0, 1'b0, 5'd0, 32'd0, lw_e);
    cyc(32'h118, 32'h00208333, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h118, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd6, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    // addi x6,x1,5: rs2 field matches the load rd but is not a source
    lw_e.pc = 32'h11C;
    cyc(32'h11C, 32'h0000A283, 1'b0, 1'b0, 5'd0, 32'd0, lw_e);
    cyc(32'h120, 32'h00508313, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h120, 32'd5, 32'h33, 32'd5, 5'd1, 5'd5, 5'd6, 3'd0, ADD, 2'd0, 1'b1, 7'b1000000, 1'b0, 1'b0));
    // flush during a load-use condition
    lw_e.pc = 32'h124;
    cyc(32'h124, 32'h0000A283, 1'b0, 1'b0, 5'd0, 32'd0, lw_e);
    cyc(32'h128, 32'h00228333, 1'b1, 1'b0, 5'd0, 32'd0, bub_e);
    // fence decodes as NOP
    cyc(32'h12C, 32'h0000000F, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h12C, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 2'd0, 1'b0, 7'b0, 1'b0, 1'b0));
    // add x7,x4,x0 with simultaneous write x4=0x55, then again
    cyc(32'h130, 32'h000203B3, 1'b0, 1'b1, 5'd4, 32'h55,
        mk(32'h130, X4_SAME_CYCLE, 32'd0, 32'd0, 5'd4, 5'd0, 5'd7, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    cyc(32'h134, 32'h000203B3, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h134, 32'h55, 32'd0, 32'd0, 5'd4, 5'd0, 5'd7, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    // write to x0 is ignored
    cyc(32'h138, 32'h000003B3, 1'b0, 1'b1, 5'd0, 32'hDEAD,
        mk(32'h138, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    cyc(32'h13C, 32'h000003B3, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h13C, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    // illegal: all-zero word, and bad low bits
    cyc(32'h140, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h140, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 2'd0, 1'b0, 7'b0, 1'b1, 1'b0));
    cyc(32'h144, 32'h002081B0, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h144, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 4'd0, 2'd0, 1'b0, 7'b0, 1'b1, 1'b0));
    // jal x0,+8: J immediate, reg_write suppressed for rd=x0
    cyc(32'h148, 32'h0080006F, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h148, 32'd0, 32'd0, 32'd8, 5'd0, 5'd8, 5'd0, 3'd0, ADD, 2'd1, 1'b1, 7'b0000010, 1'b0, 1'b0));
    cyc(32'h200, 32'h002081B3, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h200, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    drain();
    // asynchronous reset mid-cycle, then the register file reads cleared
    #1;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc(32'h204, 32'h002081B3, 1'b0, 1'b0, 5'd0, 32'd0,
        mk(32'h204, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, ADD, 2'd0, 1'b0, 7'b1000000, 1'b0, 1'b0));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
